// File: rtl/blake2_stream_sequencer.sv
// blake2_stream_sequencer
//   Packs a valid/ready byte stream (BUS_WIDTH-bit beats, din_bytes_i valid low
//   bytes) into BLOCK_WIDTH-bit blocks and sequences the BLAKE2 core through
//   init / next / final. The most recent full block is held back until either
//   another beat shows up (-> next) or the end-of-message strobe arrives
//   (-> final), so the last block always goes out with final.
// Ports
//   clk_i, reset_n_i         clock, async active-low reset
//   din_i, din_bytes_i       beat data and number of valid low bytes (1..BB)
//   valid_in_i, din_ready_o  beat handshake
//   new_hash_request_i       end-of-message strobe (may ride on the last beat)
//   hash_ready_i             core can take a command
//   digest_valid_i           core digest available
//   init_o/next_o/final_o    1-cycle core command pulses
//   block_o, data_length_o   block payload and running byte count
//   busy_o, hash_done_o      hash in progress / digest seen after final
//   proto_err_o              partial beat seen without the end strobe
module blake2_stream_sequencer #(
  parameter  int BUS_WIDTH   = 32,
  parameter  int BLOCK_WIDTH = 1024,
  parameter  int DATA_LENGTH = 128,
  localparam int WORDS       = BLOCK_WIDTH / BUS_WIDTH,
  localparam int BB          = BUS_WIDTH / 8,
  localparam int NBW         = $clog2(BB) + 1
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic [BUS_WIDTH-1:0]   din_i,
  input  logic [NBW-1:0]         din_bytes_i,
  input  logic                   valid_in_i,
  output logic                   din_ready_o,
  input  logic                   new_hash_request_i,
  input  logic                   hash_ready_i,
  input  logic                   digest_valid_i,
  output logic                   init_o,
  output logic                   next_o,
  output logic                   final_o,
  output logic [BLOCK_WIDTH-1:0] block_o,
  output logic [DATA_LENGTH-1:0] data_length_o,
  output logic                   busy_o,
  output logic                   hash_done_o,
  output logic                   proto_err_o
);
  localparam int WCW = $clog2(WORDS + 1);
  localparam int WIW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [2:0] {IDLE, FILL, FULL, CMD_WAIT, FIN_WAIT} state_e;

  state_e                          state_q;
  logic [WORDS-1:0][BUS_WIDTH-1:0] buf_q;
  logic [WCW-1:0]                  wcnt_q;
  logic [DATA_LENGTH-1:0]          cnt_q;
  logic                            gap_q;   // skip hash_ready for one cycle after a command
  logic                            eom_q;   // end strobe latched, final still owed
  logic                            clr_q;   // next issued: empty the buffer once the core is ready
  logic                            init_q, next_q, final_q, busy_q, done_q, perr_q;

  logic [BUS_WIDTH-1:0] din_m;
  logic                 accept, eom, partial, last_slot;
  logic [WIW-1:0]       widx;

  // zero the bytes above din_bytes_i
  for (genvar i = 0; i < BB; i++) begin : g_mask
    assign din_m[8*i +: 8] = (din_bytes_i > NBW'(i)) ? din_i[8*i +: 8] : 8'h00;
  end

  always_comb begin
    din_ready_o = 1'b0;
    case (state_q)
      IDLE:    din_ready_o = hash_ready_i;
      FILL:    din_ready_o = 1'b1;
      default: din_ready_o = 1'b0;
    endcase
    // keep every output low while reset is held
    din_ready_o = din_ready_o & reset_n_i;
  end

  assign accept    = valid_in_i & din_ready_o;
  assign eom       = new_hash_request_i | eom_q;
  assign partial   = din_bytes_i < NBW'(BB);
  assign widx      = wcnt_q[WIW-1:0];
  assign last_slot = (wcnt_q == WCW'(WORDS - 1));

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      buf_q   <= '0;
      wcnt_q  <= '0;
      cnt_q   <= '0;
      gap_q   <= 1'b0;
      eom_q   <= 1'b0;
      clr_q   <= 1'b0;
      init_q  <= 1'b0;
      next_q  <= 1'b0;
      final_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      init_q  <= 1'b0;
      next_q  <= 1'b0;
      final_q <= 1'b0;
      done_q  <= 1'b0;
      perr_q  <= 1'b0;
      if (accept) begin
        buf_q[widx] <= din_m;
        wcnt_q      <= wcnt_q + WCW'(1);
        cnt_q       <= cnt_q + DATA_LENGTH'(din_bytes_i);
        perr_q      <= partial & ~eom;
      end
      case (state_q)
        IDLE: begin
          if (accept || (eom && hash_ready_i)) begin
            init_q  <= 1'b1;
            busy_q  <= 1'b1;
            gap_q   <= 1'b1;
            eom_q   <= eom;
            state_q <= CMD_WAIT;
          end else if (new_hash_request_i) begin
            eom_q <= 1'b1;  // core not ready yet; remember the empty message
          end
        end
        FILL: begin
          if (eom) begin
            eom_q   <= 1'b1;
            state_q <= CMD_WAIT;
          end else if (accept && last_slot) begin
            state_q <= FULL;
          end
        end
        FULL: begin
          // end strobe beats a pending beat: the held block is the last one
          if (eom) begin
            eom_q   <= 1'b1;
            state_q <= CMD_WAIT;
          end else if (valid_in_i && hash_ready_i) begin
            next_q  <= 1'b1;
            gap_q   <= 1'b1;
            clr_q   <= 1'b1;
            state_q <= CMD_WAIT;
          end
        end
        CMD_WAIT: begin
          if (new_hash_request_i) eom_q <= 1'b1;
          if (gap_q) begin
            gap_q <= 1'b0;
          end else if (hash_ready_i) begin
            if (clr_q) begin
              buf_q   <= '0;
              wcnt_q  <= '0;
              clr_q   <= 1'b0;
              state_q <= FILL;
            end else if (eom) begin
              final_q <= 1'b1;
              gap_q   <= 1'b1;
              eom_q   <= 1'b0;
              state_q <= FIN_WAIT;
            end else begin
              state_q <= FILL;
            end
          end
        end
        FIN_WAIT: begin
          if (gap_q) begin
            gap_q <= 1'b0;
          end else if (digest_valid_i) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            buf_q   <= '0;
            wcnt_q  <= '0;
            cnt_q   <= '0;
            eom_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign init_o        = init_q;
  assign next_o        = next_q;
  assign final_o       = final_q;
  assign block_o       = buf_q;
  assign data_length_o = cnt_q;
  assign busy_o        = busy_q;
  assign hash_done_o   = done_q;
  assign proto_err_o   = perr_q;
endmodule

// File: tb/tb_blake2_stream_sequencer.sv
module tb_blake2_stream_sequencer;
  localparam int WORDS = 32;

  logic          clk, rst_n;
  logic [31:0]   din;
  logic [2:0]    din_bytes;
  logic          valid_in, din_ready, nhr, hash_ready, digest_valid;
  logic          init, next, fin, busy, hash_done, proto_err;
  logic [1023:0] block;
  logic [127:0]  data_length;

  blake2_stream_sequencer dut (
    .clk_i(clk), .reset_n_i(rst_n), .din_i(din), .din_bytes_i(din_bytes),
    .valid_in_i(valid_in), .din_ready_o(din_ready), .new_hash_request_i(nhr),
    .hash_ready_i(hash_ready), .digest_valid_i(digest_valid),
    .init_o(init), .next_o(next), .final_o(fin), .block_o(block),
    .data_length_o(data_length), .busy_o(busy), .hash_done_o(hash_done),
    .proto_err_o(proto_err)
  );

  int n_cmp = 0, n_err = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // observed commands
  int            ev_t[$];
  logic [1023:0] ev_b[$];
  logic [127:0]  ev_l[$];
  int            perr_cnt, done_cnt, multi_cnt;
  bit            busy_seen;

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rst_n) begin
        if (int'(init) + int'(next) + int'(fin) > 1) multi_cnt++;
        if (init) begin ev_t.push_back(0); ev_b.push_back(block); ev_l.push_back(data_length); end
        if (next) begin ev_t.push_back(1); ev_b.push_back(block); ev_l.push_back(data_length); end
        if (fin)  begin ev_t.push_back(2); ev_b.push_back(block); ev_l.push_back(data_length); end
        if (proto_err) perr_cnt++;
        if (hash_done) done_cnt++;
        if (busy) busy_seen = 1'b1;
      end
    end
  end

  // core model: drops ready for 1..4 cycles per command, digest when a final completes
  initial begin
    int wt;
    bit pend;
    hash_ready = 1'b1; digest_valid = 1'b0; wt = 0; pend = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        hash_ready = 1'b1; digest_valid = 1'b0; wt = 0; pend = 1'b0;
      end else begin
        digest_valid = 1'b0;
        if (init || next || fin) begin
          hash_ready = 1'b0; wt = $urandom_range(1, 4); pend = fin;
        end else if (wt > 0) begin
          wt--;
          if (wt == 0) begin
            hash_ready = 1'b1;
            digest_valid = pend;
            pend = 1'b0;
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bmask(input int n);
    return (n >= 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * n)) - 32'h1);
  endfunction

  logic [31:0] bd[$];
  int          bn[$];
  int          tmo;

  // called just after a negedge
  task automatic drive_beat(input logic [31:0] d, input int nb, input bit strobe);
    int t;
    t = 0;
    valid_in = 1'b1; din = d; din_bytes = 3'(nb);
    while (!din_ready && t < 200) begin @(negedge clk); t++; end
    if (!din_ready) tmo++;
    nhr = strobe;
    @(negedge clk);
    nhr = 1'b0; valid_in = 1'b0;
  endtask

  // message = bd/bn; expectation derived from block arithmetic on the beat list
  task automatic run_msg(input string tag, input bit strobe_with_last);
    int            nb, nblk, xperr, t, n, lim;
    int            xt[$];
    logic [1023:0] xb[$];
    logic [127:0]  xl[$];
    logic [1023:0] eb;
    longint        sum;
    nb = bd.size();
    nblk = (nb == 0) ? 1 : (nb + WORDS - 1) / WORDS;
    xt.push_back(0); xb.push_back('0); xl.push_back('0);
    for (int b = 0; b < nblk; b++) begin
      eb = '0; sum = 0;
      for (int w = 0; w < WORDS; w++)
        if (b * WORDS + w < nb) eb[w*32 +: 32] = bd[b*WORDS+w] & bmask(bn[b*WORDS+w]);
      lim = ((b + 1) * WORDS < nb) ? (b + 1) * WORDS : nb;
      for (int k = 0; k < lim; k++) sum += bn[k];
      xt.push_back((b == nblk - 1) ? 2 : 1); xb.push_back(eb); xl.push_back(128'(sum));
    end
    xperr = 0;
    for (int k = 0; k < nb; k++)
      if (bn[k] < 4 && !(k == nb - 1 && strobe_with_last)) xperr++;

    ev_t.delete(); ev_b.delete(); ev_l.delete();
    perr_cnt = 0; done_cnt = 0; multi_cnt = 0; busy_seen = 1'b0; tmo = 0;
    for (int k = 0; k < nb; k++) drive_beat(bd[k], bn[k], (k == nb - 1) && strobe_with_last);
    if (nb == 0 || !strobe_with_last) begin
      nhr = 1'b1; @(negedge clk); nhr = 1'b0;
    end
    t = 0;
    while (done_cnt == 0 && t < 2000) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);

    chk({tag, "_accept_timeout"}, tmo, 0);
    chk({tag, "_hash_done"}, done_cnt, 1);
    chk({tag, "_ncmd"}, ev_t.size(), xt.size());
    n = (ev_t.size() < xt.size()) ? ev_t.size() : xt.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_cmd%0d_type", tag, i), ev_t[i], xt[i]);
      if (xt[i] != 0) begin
        chk($sformatf("%s_cmd%0d_len", tag, i), ev_l[i], xl[i]);
        for (int w = 0; w < WORDS; w++)
          chk($sformatf("%s_cmd%0d_w%0d", tag, i, w), ev_b[i][w*32 +: 32], xb[i][w*32 +: 32]);
      end
    end
    chk({tag, "_proto_err"}, perr_cnt, xperr);
    chk({tag, "_one_hot"}, multi_cnt, 0);
    chk({tag, "_busy_seen"}, busy_seen, 1);
    chk({tag, "_busy_end"}, busy, 0);
  endtask

  task automatic rand_beats(input int n, input bit part_last);
    bd.delete(); bn.delete();
    for (int k = 0; k < n; k++) begin
      bd.push_back($urandom);
      bn.push_back((part_last && k == n - 1) ? int'($urandom_range(1, 4)) : 4);
    end
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_init"}, init, 0);
    chk({tag, "_next"}, next, 0);
    chk({tag, "_final"}, fin, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, hash_done, 0);
    chk({tag, "_perr"}, proto_err, 0);
    chk({tag, "_din_ready"}, din_ready, 0);
    chk({tag, "_len"}, data_length, 0);
    chk({tag, "_block_zero"}, (block == '0), 1);
  endtask

  initial begin
    rst_n = 1'b0; valid_in = 1'b0; nhr = 1'b0; din = '0; din_bytes = '0;
    repeat (3) @(negedge clk);
    chk_outs_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_din_ready", din_ready, 1);

    // 1 empty message
    bd.delete(); bn.delete();
    run_msg("empty", 1'b0);
    // 2 one beat, strobe after
    bd.delete(); bn.delete(); bd.push_back(32'h6161_6161); bn.push_back(4);
    run_msg("one_beat", 1'b0);
    // 3 exactly one block, both strobe timings
    rand_beats(32, 1'b0); run_msg("b32_with", 1'b1);
    rand_beats(32, 1'b0); run_msg("b32_after", 1'b0);
    // 4 one block plus a word
    rand_beats(33, 1'b0); run_msg("b33", 1'b1);
    // 5 partial last beat with the strobe
    bd.delete(); bn.delete();
    bd.push_back($urandom); bn.push_back(4);
    bd.push_back(32'h0000_00AB); bn.push_back(1);
    run_msg("partial_end", 1'b1);
    // partial beat mid-message, dirty upper bytes
    rand_beats(5, 1'b0); bn[2] = 2; run_msg("proto_mid", 1'b1);
    // two-block boundaries
    rand_beats(64, 1'b0); run_msg("b64_after", 1'b0);
    rand_beats(65, 1'b1); run_msg("b65", 1'b1);
    // randomized
    for (int r = 0; r < 6; r++) begin
      rand_beats($urandom_range(1, 100), $urandom_range(0, 1));
      run_msg($sformatf("rnd%0d", r), $urandom_range(0, 1));
    end

    // 6 reset mid-message
    rand_beats(10, 1'b0);
    for (int k = 0; k < 10; k++) drive_beat(bd[k], 4, 1'b0);
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk_outs_zero("mid_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    rand_beats(1, 1'b0); run_msg("after_reset", 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
